// File: rtl/button_capture.sv
// button_capture: synchronise, debounce and encode the four player buttons.
// Optional idle timeout is built only when BTN_TIMEOUT_EN is defined.
module button_capture #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W           = 16,
    parameter int TIMEOUT_CYCLES  = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] btn_raw,
    output logic [1:0] colour,
    output logic       colour_valid,
    output logic       multi_err,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE,
        DB_PRESS,
        HELD,
        DB_RELEASE
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Counters must be able to hold their terminal values.
    if (DEBOUNCE_CYCLES < 2 ||
        ((DEBOUNCE_CYCLES - 1) >> CNT_W) != 0 ||
        TIMEOUT_CYCLES < 1 ||
        ((TIMEOUT_CYCLES - 1) >> CNT_W) != 0) begin : g_bad_cfg
        $error("button_capture: counter parameters out of range");
    end

    logic [3:0]       r_sync1;
    logic [3:0]       r_sync2;
    logic [3:0]       w_s;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [3:0]       r_cand;
    logic [3:0]       w_cand_nxt;
    logic             w_accept;
    logic             w_single;
    logic [1:0]       w_enc;
    logic             w_cv_nxt;
    logic             w_me_nxt;
    logic [1:0]       r_colour;
    logic             r_colour_valid;
    logic             r_multi_err;
    logic             r_busy;

    assign w_s = r_sync2;

    // Two-stage synchroniser for the asynchronous button inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 4'b0000;
            r_sync2 <= 4'b0000;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // FSM state, debounce counter and candidate pattern registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_cand  <= 4'b0000;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_cand  <= w_cand_nxt;
        end
    end

    // Next-state logic: debounce press, hold, debounce release.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cand_nxt  = r_cand;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_s != 4'b0000) begin
                    w_cand_nxt  = w_s;
                    w_cnt_nxt   = '0;
                    w_state_nxt = DB_PRESS;
                end
            end
            DB_PRESS: begin
                if (w_s == 4'b0000) begin
                    w_state_nxt = IDLE;
                end else if (w_s != r_cand) begin
                    w_cand_nxt = w_s;
                    w_cnt_nxt  = '0;
                end else if (r_cnt == DB_LAST) begin
                    w_accept    = 1'b1;
                    w_state_nxt = HELD;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            HELD: begin
                if (w_s == 4'b0000) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = DB_RELEASE;
                end
            end
            DB_RELEASE: begin
                if (w_s != 4'b0000) begin
                    w_state_nxt = HELD;
                end else if (r_cnt == DB_LAST) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Classify the accepted candidate and encode a single press.
    always_comb begin
        w_single = (r_cand != 4'b0000) &&
                   ((r_cand & (r_cand - 4'd1)) == 4'b0000);
        w_enc = 2'b00;
        case (r_cand)
            4'b0010: w_enc = 2'b01;
            4'b0100: w_enc = 2'b10;
            4'b1000: w_enc = 2'b11;
            default: w_enc = 2'b00;
        endcase
        w_cv_nxt = w_accept && en && w_single;
        w_me_nxt = w_accept && en && !w_single;
    end

    // Registered outputs: strobes, held colour and busy flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_colour       <= 2'b00;
            r_colour_valid <= 1'b0;
            r_multi_err    <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            if (w_cv_nxt) begin
                r_colour <= w_enc;
            end
            r_colour_valid <= w_cv_nxt;
            r_multi_err    <= w_me_nxt;
            r_busy         <= (r_state != IDLE);
        end
    end

    assign colour       = r_colour;
    assign colour_valid = r_colour_valid;
    assign multi_err    = r_multi_err;
    assign busy         = r_busy;

`ifdef BTN_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_idle_cnt;
    logic             r_timeout;

    // Idle counter: runs while enabled in IDLE, pulses and wraps at the end.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idle_cnt <= '0;
            r_timeout  <= 1'b0;
        end else if (en && r_state == IDLE) begin
            if (r_idle_cnt == TO_LAST) begin
                r_idle_cnt <= '0;
                r_timeout  <= 1'b1;
            end else begin
                r_idle_cnt <= r_idle_cnt + CNT_ONE;
                r_timeout  <= 1'b0;
            end
        end else begin
            r_idle_cnt <= '0;
            r_timeout  <= 1'b0;
        end
    end

    assign timeout = r_timeout;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_button_capture.sv
// tb_button_capture: random and directed stimulus against a run-length
// reference model of the button debouncer.
module tb_button_capture;

    localparam int D = 4;
    localparam int T = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [3:0] btn_raw;
    logic [1:0] colour;
    logic       colour_valid;
    logic       multi_err;
    logic       busy;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    button_capture #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W(16),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .btn_raw(btn_raw),
        .colour(colour),
        .colour_valid(colour_valid),
        .multi_err(multi_err),
        .busy(busy),
        .timeout(timeout)
    );

    task automatic check(input string tag, input logic [3:0] obs,
                         input logic [3:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a press is accepted once the same nonzero pattern
    // has been seen for D+1 consecutive synchronised samples; a release
    // completes after D+1 consecutive zero samples.
    logic [3:0] m_b1, m_b2, m_prev;
    logic [1:0] m_colour;
    bit m_cv, m_me, m_busy, m_to, m_locked, m_engaged;
    int m_run, m_zrun, m_idle;
    int cv_seen, me_seen;

    task automatic model_edge();
        logic [3:0] s;
        if (reset) begin
            m_b1 = 0; m_b2 = 0; m_prev = 0;
            m_colour = 0; m_cv = 0; m_me = 0; m_busy = 0; m_to = 0;
            m_locked = 0; m_engaged = 0;
            m_run = 0; m_zrun = 0; m_idle = 0;
        end else begin
            s = m_b2;
            m_busy = m_engaged;
            m_cv = 0; m_me = 0; m_to = 0;
            if (en && !m_engaged) begin
                if (m_idle == T - 1) begin
                    m_idle = 0;
                    m_to = 1;
                end else begin
                    m_idle++;
                end
            end else begin
                m_idle = 0;
            end
            if (!m_locked) begin
                if (s == 0) m_run = 0;
                else if (s == m_prev) m_run++;
                else m_run = 1;
                if (m_run == D + 1) begin
                    m_locked = 1;
                    m_zrun = 0;
                    m_run = 0;
                    if (en) begin
                        if ($countones(s) == 1) begin
                            m_cv = 1;
                            for (int k = 0; k < 4; k++)
                                if (s[k]) m_colour = 2'(k);
                        end else begin
                            m_me = 1;
                        end
                    end
                end
            end else begin
                if (s == 0) m_zrun++;
                else m_zrun = 0;
                if (m_zrun == D + 1) begin
                    m_locked = 0;
                    m_run = 0;
                end
            end
            m_prev = s;
            m_engaged = m_locked || (m_run > 0);
            m_b2 = m_b1;
            m_b1 = btn_raw;
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [3:0] b);
        logic to_exp;
        reset = r;
        en = e;
        btn_raw = b;
        @(posedge clk);
        model_edge();
        #1;
`ifdef BTN_TIMEOUT_EN
        to_exp = m_to;
`else
        to_exp = 1'b0;
`endif
        check("colour", {2'b00, colour}, {2'b00, m_colour});
        check("colour_valid", {3'b000, colour_valid}, {3'b000, m_cv});
        check("multi_err", {3'b000, multi_err}, {3'b000, m_me});
        check("busy", {3'b000, busy}, {3'b000, m_busy});
        check("timeout", {3'b000, timeout}, {3'b000, to_exp});
        if (colour_valid) cv_seen++;
        if (multi_err) me_seen++;
    endtask

    task automatic hold(input logic e, input logic [3:0] b, input int n);
        for (int i = 0; i < n; i++) step(1'b0, e, b);
    endtask

    initial begin
        reset = 1'b1;
        en = 1'b0;
        btn_raw = 4'b0000;
        step(1'b1, 1'b0, 4'b0000);
        step(1'b1, 1'b0, 4'b0000);

        // Clean press of blue: exactly one strobe, colour 2'b10.
        cv_seen = 0;
        hold(1'b1, 4'b0100, 20);
        hold(1'b1, 4'b0000, 12);
        check("clean_count", 4'(cv_seen), 4'd1);
        check("clean_colour", {2'b00, colour}, 4'd2);

        // Bouncing green, then a steady hold.
        cv_seen = 0;
        for (int i = 0; i < 3; i++) begin
            hold(1'b1, 4'b0010, 2);
            hold(1'b1, 4'b0000, 2);
        end
        hold(1'b1, 4'b0010, 10);
        hold(1'b1, 4'b0000, 10);
        check("bounce_count", 4'(cv_seen), 4'd1);

        // Two buttons at once: error strobe, no colour.
        cv_seen = 0;
        me_seen = 0;
        hold(1'b1, 4'b1001, 10);
        hold(1'b1, 4'b0000, 10);
        check("multi_cv", 4'(cv_seen), 4'd0);
        check("multi_me", 4'(me_seen), 4'd1);

        // Press across enable is swallowed; a fresh press fires.
        cv_seen = 0;
        hold(1'b0, 4'b1000, 8);
        hold(1'b1, 4'b1000, 4);
        hold(1'b1, 4'b0000, 10);
        check("gate_none", 4'(cv_seen), 4'd0);
        hold(1'b1, 4'b1000, 10);
        hold(1'b1, 4'b0000, 10);
        check("gate_fire", 4'(cv_seen), 4'd1);

        // Release glitch, then reset while debouncing a press.
        cv_seen = 0;
        hold(1'b1, 4'b0001, 10);
        hold(1'b1, 4'b0000, 2);
        hold(1'b1, 4'b0001, 8);
        check("relglitch", 4'(cv_seen), 4'd1);
        hold(1'b1, 4'b0000, 10);
        hold(1'b1, 4'b0001, 4);
        step(1'b1, 1'b1, 4'b0001);
        hold(1'b1, 4'b0001, 10);
        hold(1'b1, 4'b0000, 10);

        // Idle with enable: timeout pulses when built.
        hold(1'b1, 4'b0000, 50);
        hold(1'b1, 4'b0100, 3);
        hold(1'b1, 4'b0000, 30);

        // Random segments of patterns, enables and resets.
        for (int seg = 0; seg < 300; seg++) begin
            logic [3:0] b;
            int pick;
            pick = $urandom_range(0, 9);
            if (pick < 2) b = 4'b0000;
            else if (pick < 7) b = 4'(1 << $urandom_range(0, 3));
            else b = 4'($urandom_range(1, 15));
            if ($urandom_range(0, 39) == 0)
                step(1'b1, 1'b1, b);
            hold($urandom_range(0, 7) != 0, b, $urandom_range(1, 12));
        end
        hold(1'b1, 4'b0000, 30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_capture.md
# button_capture

Input-side counterpart of the colour display path. It samples the four raw player buttons and synchronises and debounces them. It converts each clean single-button press into a 2-bit colour code with a one-cycle valid strobe for the WAIT state. Simultaneous presses are reported as errors, and an optional no-press timeout is provided. It sits between `ui_in[3:0]` and the WAIT state, replacing direct use of the raw buttons and the combinational decoder.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1000: consecutive stable synchronised cycles required to accept a press or a release (≥2).
- `CNT_W`, default 16: width of the debounce and timeout counters. Must hold `DEBOUNCE_CYCLES-1` and `TIMEOUT_CYCLES-1`.
- `TIMEOUT_CYCLES`, default 50000: idle cycles before `timeout` fires. Used only with `BTN_TIMEOUT_EN`.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset; clock clk.
- `en`  in  1  capture enable. When low, accepted presses are swallowed.
- `btn_raw`  in  4  asynchronous buttons, active high. Bit0=red, bit1=green, bit2=blue, bit3=yellow.
- `colour`  out  2  last accepted colour code. Reset 2'b00.
- `colour_valid`  out  1  one-cycle strobe: a new single press was accepted. Reset 0.
- `multi_err`  out  1  one-cycle strobe: the accepted pattern had >1 bit set. Reset 0.
- `busy`  out  1  high whenever FSM ≠ IDLE. Reset 0.
- `timeout`  out  1  one-cycle strobe on idle timeout. Reset 0. Tied 0 without the macro.

## Operation
Synchroniser:
- 2-FF synchroniser per bit. Its output is `s[3:0]`. Both stages reset to 0.

FSM states: IDLE, DB_PRESS, HELD, DB_RELEASE. The FSM keeps a debounce counter `cnt` and a candidate register `cand[3:0]`.
- IDLE: on `s≠0`, latch `cand=s`, set `cnt=0`, go to DB_PRESS.
- DB_PRESS:
  - `s==0`: go to IDLE.
  - `s≠cand` with `s≠0`: set `cand=s`, `cnt=0`, stay.
  - `s==cand` and `cnt==DEBOUNCE_CYCLES-1`: accept and go to HELD.
  - Otherwise: `cnt++`.
- Accept rules:
  - Single bit set in `cand` and `en=1`: `colour` is loaded with the encoded value (bit0→00, bit1→01, bit2→10, bit3→11) and `colour_valid` pulses.
  - More than one bit set and `en=1`: `multi_err` pulses and `colour` is unchanged.
  - `en=0`: no strobe, `colour` is unchanged, and the FSM still goes to HELD. A press held across enable therefore never fires.
- HELD: on `s==0`, set `cnt=0` and go to DB_RELEASE. Pattern changes while still nonzero are ignored; adding a second button produces no event.
- DB_RELEASE:
  - `s≠0`: back to HELD.
  - `cnt==DEBOUNCE_CYCLES-1`: go to IDLE.
  - Otherwise: `cnt++`.
- A new press is only recognised after a fully debounced release.
- `colour_valid` and `multi_err` are never high in the same cycle. Each accept produces at most one strobe.
- Reset mid-operation: all state returns to IDLE and the strobes clear. A button still held after reset is re-detected as a new press after the full latency.

## Timing
- Latency: if `btn_raw` is stable before edge 0, `colour_valid`/`multi_err` is high for exactly the one cycle after edge `DEBOUNCE_CYCLES+2`.
- Press glitch: a press shorter than `DEBOUNCE_CYCLES` synchronised cycles produces no event.
- Release glitch: a release glitch shorter than `DEBOUNCE_CYCLES` cycles keeps the FSM in HELD.
- Next press: the earliest next accept comes `DEBOUNCE_CYCLES+2` edges after the release debounce completes.
- Output registers: `colour` changes on the same edge the strobe rises and is held until the next accept. `busy` is registered from the FSM state.

## Configuration
- `BTN_TIMEOUT_EN` defined:
  - An idle counter increments each cycle while `en=1` and the FSM is in IDLE. It clears to 0 when `en=0` or the FSM leaves IDLE.
  - When it reaches `TIMEOUT_CYCLES-1`, `timeout` pulses for one cycle and the counter wraps to 0, so it repeats every `TIMEOUT_CYCLES` cycles.
- `BTN_TIMEOUT_EN` undefined: the counter is not built and `timeout` is constant 0. All other behaviour is identical.

## Test plan
Sim parameters for all scenarios: `DEBOUNCE_CYCLES=4`, `TIMEOUT_CYCLES=20`.
- Clean press: `en=1`, `btn_raw=4'b0100` held 20 cycles, then 0. Expect `colour=2'b10` and `colour_valid` high for one cycle after edge 6; `busy` high from edge 3 until release debounce completes; no second strobe.
- Bounce: `btn_raw` toggles 0010/0000 every 2 cycles for 12 cycles, then holds 0010. Expect no strobe during toggling, then exactly one `colour_valid` with `colour=2'b01`, 6 edges after the hold begins.
- Multi-press: `btn_raw=4'b1001` held 10 cycles. Expect one `multi_err` pulse, `colour_valid` never high, `colour` unchanged.
- Enable gating: press `4'b1000` with `en=0`, raise `en` while still held, then release. Expect no strobe. A new press of `4'b1000` yields `colour=2'b11` with `colour_valid`.
- Release bounce and reset: hold `0001`, release for 2 cycles, re-press. Expect no new strobe. Then assert `reset` mid-DB_PRESS. Expect all outputs 0 next cycle and an FSM restart.
- Timeout (macro on): `en=1`, no buttons. Expect `timeout` pulses every 20 cycles. A press clears the count. With the macro off, `timeout` stays 0.
